layer_seq_ctrl: RTL



---
 rtl/layer_seq_ctrl.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/layer_seq_ctrl.sv
// Sequencer for one fully-connected layer: streams activations onto the shared neuron
// bus, collects every neuron's result, then writes them serially to the next layer buffer.
module layer_seq_ctrl #(
    parameter int NUM_INPUTS  = 30,
    parameter int NUM_NEURONS = 30,
    parameter int DATA_WIDTH  = 16,
    parameter int TIMEOUT     = 64,
    localparam int IAW = (NUM_INPUTS  > 1) ? $clog2(NUM_INPUTS)  : 1,
    localparam int OAW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    output logic [IAW-1:0]                    in_rd_addr,
    input  logic [DATA_WIDTH-1:0]             in_rd_data,
    output logic [DATA_WIDTH-1:0]             neur_in_data,
    output logic                              neur_in_valid,
    input  logic [NUM_NEURONS-1:0]            neur_out_valid,
    input  logic [NUM_NEURONS*DATA_WIDTH-1:0] neur_out_data,
    output logic                              out_wr_en,
    output logic [OAW-1:0]                    out_wr_addr,
    output logic [DATA_WIDTH-1:0]             out_wr_data,
    output logic                              busy,
    output logic                              done,
    output logic                              err
);

    typedef enum logic [2:0] {
        S_IDLE, S_PRIME, S_STREAM, S_WAIT, S_DRAIN, S_FIN
    } state_t;

    localparam int ICW = $clog2(NUM_INPUTS + 1);
    localparam int WCW = $clog2(TIMEOUT + 1);
    localparam logic [IAW-1:0] RD_FIRST  = IAW'((NUM_INPUTS > 1) ? 1 : 0);
    localparam logic [IAW-1:0] RD_LAST   = IAW'(NUM_INPUTS - 1);
    localparam logic [ICW-1:0] IN_ALL    = ICW'(NUM_INPUTS);
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT - 1);
    localparam logic [OAW-1:0] WR_LAST   = OAW'(NUM_NEURONS - 1);

    state_t                 state_q;
    logic [IAW-1:0]         rd_addr_q;
    logic [ICW-1:0]         in_cnt_q;
    logic                   vld_q;
    logic [DATA_WIDTH-1:0]  hold_q;
    logic [NUM_NEURONS-1:0] pending_q;
    logic [NUM_NEURONS-1:0] hit_d;
    logic [NUM_NEURONS-1:0] pending_d;
    logic [DATA_WIDTH-1:0]  cap_q [NUM_NEURONS];
    logic [WCW-1:0]         wait_cnt_q;
    logic                   wr_en_q;
    logic [OAW-1:0]         wr_addr_q;
    logic [DATA_WIDTH-1:0]  wr_data_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   err_q;
    logic [DATA_WIDTH-1:0]  slot0_d;

    // Results are only accepted while a frame is in flight and only once per neuron.
    always_comb begin
        hit_d = '0;
        if (state_q == S_STREAM || state_q == S_WAIT) begin
            hit_d = neur_out_valid & pending_q;
        end
        pending_d = pending_q & ~hit_d;
        slot0_d   = hit_d[0] ? neur_out_data[DATA_WIDTH-1:0] : cap_q[0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            rd_addr_q  <= '0;
            in_cnt_q   <= '0;
            vld_q      <= 1'b0;
            hold_q     <= '0;
            pending_q  <= '0;
            wait_cnt_q <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            for (int i = 0; i < NUM_NEURONS; i++) begin
                cap_q[i] <= '0;
            end
        end else begin
            done_q    <= 1'b0;
            pending_q <= pending_d;
            for (int i = 0; i < NUM_NEURONS; i++) begin
                if (hit_d[i]) begin
                    cap_q[i] <= neur_out_data[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
            if (vld_q) begin
                hold_q <= in_rd_data;
            end

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q   <= S_PRIME;
                        busy_q    <= 1'b1;
                        err_q     <= 1'b0;
                        pending_q <= '1;
                        rd_addr_q <= '0;
                        in_cnt_q  <= '0;
                        for (int i = 0; i < NUM_NEURONS; i++) begin
                            cap_q[i] <= '0;
                        end
                    end
                end
                S_PRIME: begin
                    state_q   <= S_STREAM;
                    vld_q     <= 1'b1;
                    in_cnt_q  <= ICW'(1);
                    rd_addr_q <= RD_FIRST;
                end
                S_STREAM: begin
                    if (in_cnt_q == IN_ALL) begin
                        vld_q      <= 1'b0;
                        wait_cnt_q <= '0;
                        state_q    <= S_WAIT;
                    end else begin
                        in_cnt_q  <= in_cnt_q + ICW'(1);
                        rd_addr_q <= (rd_addr_q == RD_LAST) ? rd_addr_q : rd_addr_q + IAW'(1);
                    end
                end
                S_WAIT: begin
                    if (pending_d == '0 || wait_cnt_q == WAIT_LAST) begin
                        if (pending_d != '0) begin
                            err_q <= 1'b1;
                        end
                        state_q   <= S_DRAIN;
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= '0;
                        wr_data_q <= slot0_d;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + WCW'(1);
                    end
                end
                S_DRAIN: begin
                    if (wr_addr_q == WR_LAST) begin
                        wr_en_q <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_FIN;
                    end else begin
                        wr_addr_q <= wr_addr_q + OAW'(1);
                        wr_data_q <= cap_q[wr_addr_q + OAW'(1)];
                    end
                end
                S_FIN: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // The buffer returns data one cycle after the address, so the word is forwarded in its
    // valid cycle; hold_q keeps the bus stable (and known) between frames.
    assign neur_in_data  = vld_q ? in_rd_data : hold_q;
    assign neur_in_valid = vld_q;
    assign in_rd_addr    = rd_addr_q;
    assign out_wr_en     = wr_en_q;
    assign out_wr_addr   = wr_addr_q;
    assign out_wr_data   = wr_data_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;

endmodule
